// File: rtl/sram_controller_if.sv
// MEM-stage request/response bundle between the pipeline and sram_controller.
interface sram_controller_if;
    logic        rd_en;
    logic        wr_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;

    modport master (output rd_en, wr_en, address, write_data, input read_data, ready);
    modport slave  (input rd_en, wr_en, address, write_data, output read_data, ready);
endinterface

// File: rtl/sram_controller.sv
// Sequences a 32-bit load/store onto a 16-bit async SRAM as two half-word phases
// with programmable wait states, freezing the pipeline through ready.
module sram_controller #(
    parameter int unsigned ADDR_W      = 18,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic              clk,
    input  logic              rst,
    sram_controller_if.slave  bus,
    inout  wire  [15:0]       SRAM_DQ,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    output logic              SRAM_CE_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N
);
    localparam int unsigned       WCNT_W    = 4;
    localparam int unsigned       PAIR_W    = ADDR_W - 1;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

    state_t              r_state, w_state_nx;
    logic [WCNT_W-1:0]   r_wcnt, w_wcnt_nx;
    logic                r_is_wr;
    logic [PAIR_W-1:0]   r_pair;
    logic [31:0]         r_wdata;
    logic [31:0]         r_read_data, w_read_data_nx;
    logic [ADDR_W-1:0]   r_sram_addr, w_sram_addr_nx;
    logic                r_ce_n, w_ce_n_nx;
    logic                r_oe_n, w_oe_n_nx;
    logic                r_we_n, w_we_n_nx;
    logic                r_dq_oe, w_dq_oe_nx;
    logic [15:0]         r_dq_out, w_dq_out_nx;
    logic                w_req, w_last, w_is_wr_sel, w_ready;
    logic [31:0]         w_offset, w_wdata_sel;
    logic [PAIR_W-1:0]   w_pair_in, w_pair_sel;

    assign w_req       = bus.rd_en | bus.wr_en;
    assign w_last      = (r_wcnt == WCNT_LAST);
    assign w_offset    = bus.address - 32'(BASE_ADDR);
    // Upper bits of the half-word index; the phase supplies bit 0.
    assign w_pair_in   = PAIR_W'(w_offset >> 2);
    assign w_is_wr_sel = (r_state == S_IDLE) ? bus.wr_en        : r_is_wr;
    assign w_pair_sel  = (r_state == S_IDLE) ? w_pair_in        : r_pair;
    assign w_wdata_sel = (r_state == S_IDLE) ? bus.write_data   : r_wdata;

    // Next state, wait counter, read capture and next pin values.
    always_comb begin
        w_state_nx     = r_state;
        w_wcnt_nx      = r_wcnt;
        w_read_data_nx = r_read_data;
        w_sram_addr_nx = r_sram_addr;
        w_ce_n_nx      = 1'b1;
        w_oe_n_nx      = 1'b1;
        w_we_n_nx      = 1'b1;
        w_dq_oe_nx     = 1'b0;
        w_dq_out_nx    = r_dq_out;

        unique case (r_state)
            S_IDLE: begin
                if (w_req) begin
                    w_state_nx = S_LO;
                    w_wcnt_nx  = '0;
                end
            end
            S_LO: begin
                if (w_last) begin
                    w_state_nx = S_HI;
                    w_wcnt_nx  = '0;
                    if (!r_is_wr) w_read_data_nx[15:0] = SRAM_DQ;
                end else begin
                    w_wcnt_nx = r_wcnt + WCNT_W'(1);
                end
            end
            S_HI: begin
                if (w_last) begin
                    w_state_nx = S_DONE;
                    w_wcnt_nx  = '0;
                    if (!r_is_wr) w_read_data_nx[31:16] = SRAM_DQ;
                end else begin
                    w_wcnt_nx = r_wcnt + WCNT_W'(1);
                end
            end
            S_DONE:  w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase

        // Pins are registered from the next state so they line up with the phase.
        if (w_state_nx == S_LO || w_state_nx == S_HI) begin
            w_ce_n_nx      = 1'b0;
            w_sram_addr_nx = {w_pair_sel, w_state_nx == S_HI};
            if (w_is_wr_sel) begin
                w_dq_oe_nx  = 1'b1;
                w_we_n_nx   = (w_wcnt_nx == WCNT_LAST);
                w_dq_out_nx = (w_state_nx == S_HI) ? w_wdata_sel[31:16] : w_wdata_sel[15:0];
            end else begin
                w_oe_n_nx = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_wcnt  <= w_wcnt_nx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_is_wr     <= 1'b0;
            r_pair      <= '0;
            r_wdata     <= '0;
            r_read_data <= '0;
            r_sram_addr <= '0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_dq_oe     <= 1'b0;
            r_dq_out    <= '0;
        end else begin
            if (r_state == S_IDLE && w_req) begin
                r_is_wr <= bus.wr_en;
                r_pair  <= w_pair_in;
                r_wdata <= bus.write_data;
            end
            r_read_data <= w_read_data_nx;
            r_sram_addr <= w_sram_addr_nx;
            r_ce_n      <= w_ce_n_nx;
            r_oe_n      <= w_oe_n_nx;
            r_we_n      <= w_we_n_nx;
            r_dq_oe     <= w_dq_oe_nx;
            r_dq_out    <= w_dq_out_nx;
        end
    end

    // Freeze whenever an access is pending or in flight.
    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            S_IDLE:  w_ready = ~w_req;
            S_DONE:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    assign bus.ready     = w_ready;
    assign bus.read_data = r_read_data;
    assign SRAM_ADDR     = r_sram_addr;
    assign SRAM_CE_N     = r_ce_n;
    assign SRAM_OE_N     = r_oe_n;
    assign SRAM_WE_N     = r_we_n;
    assign SRAM_DQ       = r_dq_oe ? r_dq_out : {16{1'bz}};
endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: three instances (W=1,2,3) each with an SRAM model,
// directed and randomized accesses checked against a half-word reference map.
`timescale 1ns/1ps
module tb_sram_controller;
    localparam int unsigned NI   = 3;
    localparam int unsigned AW   = 18;
    localparam int unsigned BASE = 1024;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [2:0]    rd_v = '0;
    logic [2:0]    wr_v = '0;
    logic [31:0]   addr_a  [NI];
    logic [31:0]   wdata_a [NI];
    logic [31:0]   rdata_a [NI];
    logic [AW-1:0] saddr_a [NI];
    logic [2:0]    rdy_v, ce_v, oe_v, we_v;
    logic [15:0]   ref_mem [int];

    for (genvar i = 0; i < NI; i++) begin : g_inst
        sram_controller_if bus ();
        wire  [15:0]   dq;
        logic [AW-1:0] sa;
        logic          ce_n, oe_n, we_n;
        logic [15:0]   mem [0:(1<<AW)-1];

        sram_controller #(.ADDR_W(AW), .WAIT_CYCLES(i + 1), .BASE_ADDR(BASE)) dut (
            .clk(clk), .rst(rst_n), .bus(bus.slave), .SRAM_DQ(dq), .SRAM_ADDR(sa),
            .SRAM_CE_N(ce_n), .SRAM_OE_N(oe_n), .SRAM_WE_N(we_n));

        assign bus.rd_en      = rd_v[i];
        assign bus.wr_en      = wr_v[i];
        assign bus.address    = addr_a[i];
        assign bus.write_data = wdata_a[i];
        assign rdata_a[i]     = bus.read_data;
        assign rdy_v[i]       = bus.ready;
        assign saddr_a[i]     = sa;
        assign ce_v[i]        = ce_n;
        assign oe_v[i]        = oe_n;
        assign we_v[i]        = we_n;

        // Asynchronous SRAM: drives on OE, stores while WE is low.
        assign dq = (!ce_n && !oe_n && we_n) ? mem[sa] : 16'bz;
        always @(posedge clk) if (!ce_n && !we_n) mem[sa] <= dq;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] ref_lo(input logic [31:0] a);
        logic [31:0] hw;
        hw = ((a - 32'(BASE)) >> 1) % 32'(1 << AW);
        hw = hw - (hw % 2);
        return AW'(hw);
    endfunction

    function automatic int key(input int k, input logic [AW-1:0] hw);
        return k * (1 << 20) + int'(hw);
    endfunction

    function automatic logic [15:0] ref_get(input int kk);
        if (ref_mem.exists(kk)) return ref_mem[kk];
        return 16'h0;
    endfunction

    function automatic void ref_store(input int k, input logic [31:0] a, input logic [31:0] d);
        logic [AW-1:0] lo;
        lo = ref_lo(a);
        ref_mem[key(k, lo)]                 = d[15:0];
        ref_mem[key(k, {lo[AW-1:1], 1'b1})] = d[31:16];
    endfunction

    function automatic logic [31:0] ref_load(input int k, input logic [31:0] a);
        logic [AW-1:0] lo;
        lo = ref_lo(a);
        return {ref_get(key(k, {lo[AW-1:1], 1'b1})), ref_get(key(k, lo))};
    endfunction

    // One access from IDLE to DONE; called at posedge+1, returns at posedge+1.
    task automatic access(input int k, input bit w, input bit r, input logic [31:0] a,
                          input logic [31:0] d, output int freeze, output logic [31:0] rdat,
                          output int we_pulses, output int we_low, output int addr_bad,
                          output int ce_cyc);
        int          wc;
        bit          done;
        logic        prev_we;
        logic [AW-1:0] lo, exp_a;
        wc = k + 1; done = 0; prev_we = 1'b1; lo = ref_lo(a);
        freeze = 0; rdat = '0; we_pulses = 0; we_low = 0; addr_bad = 0; ce_cyc = 0;
        addr_a[k] = a; wdata_a[k] = d; wr_v[k] = w; rd_v[k] = r;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (rdy_v[k]) begin
                done = 1;
                rdat = rdata_a[k];
            end else begin
                freeze++;
                if (!ce_v[k]) begin
                    exp_a = (ce_cyc <= wc) ? lo : {lo[AW-1:1], 1'b1};
                    if (saddr_a[k] !== exp_a) addr_bad++;
                    ce_cyc++;
                end
                if (!we_v[k]) we_low++;
            end
            if (prev_we == 1'b0 && we_v[k] == 1'b1) we_pulses++;
            prev_we = we_v[k];
        end
        chk("access_completes", 64'(done), 64'd1);
        @(posedge clk); #1;
        wr_v[k] = 1'b0; rd_v[k] = 1'b0;
    endtask

    initial begin
        int          fz, wp, wl, ab, cc, zeros, highs, bad, wc;
        logic [31:0] rd, d, a, d1, pool [6];
        bit          is_st;
        for (int k = 0; k < NI; k++) begin addr_a[k] = 32'd0; wdata_a[k] = 32'd0; end

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ready",  64'(rdy_v), 64'h7);
        chk("rst_ce_n",   64'(ce_v),  64'h7);
        chk("rst_oe_we",  64'({oe_v, we_v}), 64'h3f);
        chk("rst_rdata",  64'(rdata_a[0]), 64'h0);
        chk("rst_saddr",  64'(saddr_a[0]), 64'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Store/load round trip at W=1
        access(0, 1, 0, 32'd1028, 32'hDEADBEEF, fz, rd, wp, wl, ab, cc);
        ref_store(0, 32'd1028, 32'hDEADBEEF);
        chk("rt_st_freeze", 64'(fz), 64'd5);
        chk("rt_st_we_pulses", 64'(wp), 64'd2);
        chk("rt_st_we_low", 64'(wl), 64'd2);
        chk("rt_st_addr", 64'(ab), 64'd0);
        chk("rt_mem_hw2", 64'(g_inst[0].mem[2]), 64'hBEEF);
        chk("rt_mem_hw3", 64'(g_inst[0].mem[3]), 64'hDEAD);
        access(0, 0, 1, 32'd1028, 32'h0, fz, rd, wp, wl, ab, cc);
        chk("rt_ld_freeze", 64'(fz), 64'd5);
        chk("rt_ld_data", 64'(rd), 64'hDEADBEEF);
        chk("rt_ld_we_low", 64'(wl), 64'd0);

        // Timing sweep for W=2,3
        for (int k = 1; k < NI; k++) begin
            wc = k + 1;
            a  = BASE + $urandom_range(0, 4000);
            d  = $urandom;
            access(k, 1, 0, a, d, fz, rd, wp, wl, ab, cc);
            ref_store(k, a, d);
            chk("sw_st_freeze", 64'(fz), 64'(2 * wc + 3));
            chk("sw_st_we_low", 64'(wl), 64'(2 * wc));
            chk("sw_st_we_pulses", 64'(wp), 64'd2);
            chk("sw_st_ce_cyc", 64'(cc), 64'(2 * wc + 2));
            chk("sw_st_addr", 64'(ab), 64'd0);
            access(k, 0, 1, a, 32'h0, fz, rd, wp, wl, ab, cc);
            chk("sw_ld_freeze", 64'(fz), 64'(2 * wc + 3));
            chk("sw_ld_data", 64'(rd), 64'(d));
        end

        // Randomized stores/loads, including an address below BASE that wraps
        for (int k = 0; k < NI; k++) begin
            wc = k + 1;
            pool[0] = 32'd1020;
            pool[1] = 32'd1024;
            for (int p = 2; p < 6; p++) pool[p] = BASE + $urandom_range(0, 8191);
            for (int p = 0; p < 6; p++) begin
                d = $urandom;
                access(k, 1, 0, pool[p], d, fz, rd, wp, wl, ab, cc);
                ref_store(k, pool[p], d);
                chk("rnd_pre_addr", 64'(ab), 64'd0);
            end
            for (int n = 0; n < 20; n++) begin
                a = pool[$urandom_range(0, 5)];
                is_st = 1'($urandom_range(0, 1));
                d = $urandom;
                access(k, is_st, !is_st, a, d, fz, rd, wp, wl, ab, cc);
                chk("rnd_freeze", 64'(fz), 64'(2 * wc + 3));
                chk("rnd_addr", 64'(ab), 64'd0);
                if (is_st) ref_store(k, a, d);
                else chk("rnd_ld_data", 64'(rd), 64'(ref_load(k, a)));
            end
        end

        // Back-to-back store then load, requests held across DONE
        d1 = 32'h12345678;
        addr_a[0] = 32'd2048; wdata_a[0] = d1; wr_v[0] = 1'b1;
        zeros = 0; highs = 0; rd = '0;
        for (int c = 0; c < 100 && highs < 2; c++) begin
            @(negedge clk);
            if (rdy_v[0]) begin
                highs++;
                rd = rdata_a[0];
                if (highs == 1) begin
                    @(posedge clk); #1;
                    wr_v[0] = 1'b0; rd_v[0] = 1'b1;
                end
            end else begin
                zeros++;
            end
        end
        chk("b2b_done", 64'(highs), 64'd2);
        chk("b2b_freeze", 64'(zeros), 64'd10);
        chk("b2b_data", 64'(rd), 64'(d1));
        @(posedge clk); #1;
        rd_v[0] = 1'b0;
        ref_store(0, 32'd2048, d1);

        // Both requests together: write wins, read_data untouched
        d = $urandom;
        access(0, 1, 1, 32'd3000, d, fz, rd, wp, wl, ab, cc);
        ref_store(0, 32'd3000, d);
        chk("prio_we_pulses", 64'(wp), 64'd2);
        chk("prio_rdata_held", 64'(rd), 64'(d1));
        access(0, 0, 1, 32'd3000, 32'h0, fz, rd, wp, wl, ab, cc);
        chk("prio_ld_data", 64'(rd), 64'(d));

        // Idle for 100 cycles
        bad = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (rdy_v[0] !== 1'b1 || ce_v[0] !== 1'b1 || oe_v[0] !== 1'b1 || we_v[0] !== 1'b1) bad++;
        end
        chk("idle_bad_cycles", 64'(bad), 64'd0);
        @(posedge clk); #1;

        // Reset in the middle of HI during a write
        addr_a[0] = 32'd1500; wdata_a[0] = 32'hA5A5_5A5A; wr_v[0] = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_hi_active", 64'({ce_v[0], we_v[0]}), 64'd0);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", 64'({ce_v[0], oe_v[0], we_v[0]}), 64'h7);
        chk("rst_mid_rdata", 64'(rdata_a[0]), 64'h0);
        chk("rst_mid_saddr", 64'(saddr_a[0]), 64'h0);
        chk("rst_mid_ready_req", 64'(rdy_v[0]), 64'd0);
        wr_v[0] = 1'b0;
        #1;
        chk("rst_mid_ready_idle", 64'(rdy_v[0]), 64'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        access(0, 0, 1, 32'd2048, 32'h0, fz, rd, wp, wl, ab, cc);
        chk("post_rst_freeze", 64'(fz), 64'd5);
        chk("post_rst_data", 64'(rd), 64'(d1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
